// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Read-side output stage of the asynchronous FIFO. Turns the
//                registered-empty / read-strobe / one-cycle-late memory data
//                interface into a first-word-fall-through valid/ready stream
//                using a 2-entry skid buffer, sustaining one word per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    // Number of skid-buffer slots; strobes stop once held + in-flight words
    // would reach this after the current pop.
    localparam logic [2:0] c_DEPTH = 3'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]            r_buf_cnt;   // words held, entry 0 is the head
    logic                  r_inflight;  // strobe issued last cycle, rdata arrives now
    logic [DATA_WIDTH-1:0] r_entry0;    // head of the buffer, drives m_data
    logic [DATA_WIDTH-1:0] r_entry1;    // second word, shifts to the head on pop
    logic [CNT_WIDTH-1:0]  r_rd_count;  // words accepted by the consumer

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic       w_valid;        // buffer holds at least one word
    logic       w_pop;          // consumer takes the head this cycle
    logic [2:0] w_occ_after;    // held + in-flight words after this cycle's pop
    logic       w_room;         // a new strobe still fits in the buffer
    logic       w_ren;          // read strobe towards the FIFO core
    logic [1:0] w_slot;         // buffer index the arriving word is written to
    logic       w_wr0;          // arriving word goes to entry 0
    logic       w_wr1;          // arriving word goes to entry 1
    logic [1:0] w_buf_cnt_nxt;  // occupancy after this edge

    // Handshake, occupancy and strobe decision for the current cycle
    always_comb begin
        w_valid     = (r_buf_cnt != 2'd0);
        w_pop       = w_valid & m_ready;

        // Pop implies r_buf_cnt >= 1, so the subtraction never underflows.
        w_occ_after = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

        // The m_ready -> r_en path is combinational on purpose: a pop this
        // cycle frees a slot for the word requested now, which is what keeps
        // the stream at one word per cycle.
        w_room      = (w_occ_after < c_DEPTH);
        w_ren       = ~rrst & ~empty & w_room;

        // The arriving word lands behind whatever survives this cycle's pop.
        w_slot      = r_buf_cnt - {1'b0, w_pop};
        w_wr0       = r_inflight & (w_slot == 2'd0);
        w_wr1       = r_inflight & (w_slot == 2'd1);

        w_buf_cnt_nxt = r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end

    // ------------------------------------------------------------------------
    // Occupancy and in-flight tracking
    // ------------------------------------------------------------------------

    // Reset discards every held and in-flight word; r_en is low during the
    // reset cycle, so the rdata that follows reset is never captured.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_buf_cnt  <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_buf_cnt  <= w_buf_cnt_nxt;
            r_inflight <= w_ren;
        end
    end

    // ------------------------------------------------------------------------
    // Skid-buffer data path
    // ------------------------------------------------------------------------

    // Head register: takes the arriving word when it becomes the head,
    // otherwise advances from entry 1 on a pop and holds on a stall.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_entry0 <= '0;
        end else if (w_wr0) begin
            r_entry0 <= rdata;
        end else if (w_pop) begin
            r_entry0 <= r_entry1;
        end
    end

    // Second register: only ever written by an arriving word while the head
    // is occupied and not being popped.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_entry1 <= '0;
        end else if (w_wr1) begin
            r_entry1 <= rdata;
        end
    end

    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------

    // Delivered-word counter, wraps naturally at its width.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_rd_count <= '0;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign r_en     = w_ren;
    assign m_valid  = w_valid;
    assign m_data   = r_entry0;
    assign rd_count = r_rd_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_stream
//  Description : Self-checking bench for fifo_rd_stream. Directed vector table
//                for reset and latency, hand sequences for throughput,
//                backpressure and mid-stream reset, then randomized stress
//                against a word/arrival-time reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          rclk = 1'b0;
    logic          rrst;
    logic          empty;
    logic          r_en;
    logic [DW-1:0] rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] rd_count;

    int total = 0;
    int bad   = 0;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .empty    (empty),
        .r_en     (r_en),
        .rdata    (rdata),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .rd_count (rd_count)
    );

    always #5 rclk = ~rclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic          rst;
        logic          emp;
        logic          rdy;
        logic [DW-1:0] rd;
        logic          x_ren;
        logic          x_val;
        logic          chk_d;
        logic [DW-1:0] x_dat;
        logic [CW-1:0] x_cnt;
    } vec_t;

    vec_t tbl [16];

    // ------------------------------------------------------------------------
    // Reference model: the bench plays the FIFO core (src_q) and records each
    // strobed word with the cycle from which it must be visible (strobe + 2).
    // ------------------------------------------------------------------------
    logic [DW-1:0] src_q [$];
    logic [DW-1:0] exp_w [$];
    int            exp_t [$];
    int            cyc;
    logic [CW-1:0] mdl_cnt;
    logic          infl_m;
    logic [DW-1:0] infl_word;
    int            delivered;
    int            ren_run, ren_best, val_run, val_best, ren_seen;

    task automatic model_clear();
        exp_w.delete();
        exp_t.delete();
        mdl_cnt = '0;
        infl_m  = 1'b0;
    endtask

    task automatic run_cycle(input logic rst_i, input logic block, input logic rdy);
        logic x_val, x_pop, x_ren;
        int   occ;
        rrst    = rst_i;
        empty   = block || (src_q.size() == 0);
        m_ready = rdy;
        rdata   = infl_m ? infl_word : 8'($urandom);
        #3;
        x_val = (exp_w.size() > 0) && (exp_t[0] <= cyc);
        x_pop = x_val && rdy;
        occ   = exp_w.size() - (x_pop ? 1 : 0);
        x_ren = !rst_i && !empty && (occ < 2);
        chk("r_en", r_en, x_ren);
        chk("m_valid", m_valid, x_val);
        if (x_val) chk("m_data", m_data, exp_w[0]);
        chk("rd_count", rd_count, mdl_cnt);
        chk("r_en_while_empty", r_en & empty, 0);
        chk("occupancy_invariant", (int'(dut.r_buf_cnt) + int'(dut.r_inflight)) <= 2, 1);
        if (r_en) ren_seen++;
        ren_run = r_en ? ren_run + 1 : 0;
        val_run = m_valid ? val_run + 1 : 0;
        if (ren_run > ren_best) ren_best = ren_run;
        if (val_run > val_best) val_best = val_run;
        if (rst_i) begin
            model_clear();
        end else begin
            if (x_pop) begin
                void'(exp_w.pop_front());
                void'(exp_t.pop_front());
                mdl_cnt++;
                delivered++;
            end
            if (x_ren) begin
                infl_word = src_q.pop_front();
                exp_w.push_back(infl_word);
                exp_t.push_back(cyc + 2);
                infl_m = 1'b1;
            end else begin
                infl_m = 1'b0;
            end
        end
        @(posedge rclk);
        #1;
        cyc++;
    endtask

    task automatic clear_streaks();
        ren_run = 0; ren_best = 0; val_run = 0; val_best = 0; ren_seen = 0;
    endtask

    initial begin
        //            rst   emp   rdy   rdata    ren   val   chkd  data     count
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'h00,  1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h00,  1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h33,  1'b1, 1'b0, 1'b1, 8'h00, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'hA5,  1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h5A,  1'b0, 1'b1, 1'b1, 8'hA5, 16'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h00,  1'b0, 1'b0, 1'b0, 8'h00, 16'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h00,  1'b0, 1'b0, 1'b0, 8'h00, 16'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h00,  1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h44,  1'b1, 1'b0, 1'b1, 8'h00, 16'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h11,  1'b1, 1'b0, 1'b1, 8'h00, 16'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h22,  1'b0, 1'b1, 1'b1, 8'h11, 16'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h99,  1'b0, 1'b1, 1'b1, 8'h11, 16'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h98,  1'b1, 1'b1, 1'b1, 8'h11, 16'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h33,  1'b0, 1'b1, 1'b1, 8'h22, 16'd1};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 8'h77,  1'b0, 1'b1, 1'b1, 8'h33, 16'd2};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00,  1'b0, 1'b0, 1'b0, 8'h00, 16'd3};

        rrst = 1'b1; empty = 1'b1; m_ready = 1'b0; rdata = '0;
        @(posedge rclk);
        #1;

        for (int i = 0; i < 16; i++) begin
            rrst    = tbl[i].rst;
            empty   = tbl[i].emp;
            m_ready = tbl[i].rdy;
            rdata   = tbl[i].rd;
            #3;
            chk($sformatf("vec%0d_r_en", i), r_en, tbl[i].x_ren);
            chk($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].x_val);
            if (tbl[i].chk_d) chk($sformatf("vec%0d_m_data", i), m_data, tbl[i].x_dat);
            chk($sformatf("vec%0d_rd_count", i), rd_count, tbl[i].x_cnt);
            @(posedge rclk);
            #1;
        end

        // Bring DUT and model to a common reset state.
        rrst = 1'b1; empty = 1'b1; m_ready = 1'b0;
        @(posedge rclk);
        #1;
        model_clear();
        cyc = 0;
        delivered = 0;
        clear_streaks();
        run_cycle(1'b1, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0);

        // Full throughput: 16 words back to back.
        for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
        clear_streaks();
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0, 1'b1);
        chk("tput_ren_streak", ren_best, 16);
        chk("tput_valid_streak", val_best, 16);
        chk("tput_rd_count", rd_count, 16);

        // Backpressure: stall the consumer with words still arriving.
        for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h10 + i));
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b1);
        clear_streaks();
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, 1'b0);
        chk("stall_ren_count", ren_seen, 0);
        chk("stall_buf_full", dut.r_buf_cnt, 2);
        for (int i = 0; i < 30; i++) run_cycle(1'b0, 1'b0, 1'b1);
        chk("bp_rd_count", rd_count, 32);

        // Reset while streaming (one held, one in flight).
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h40 + i));
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b1, 1'b1);
        chk("rst_mid_count", rd_count, 0);
        // Reset with the buffer full.
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b1);
        chk("rst_full_valid", m_valid, 0);
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h60 + i));
        for (int i = 0; i < 16; i++) run_cycle(1'b0, 1'b0, 1'b1);

        // Random stress over 10k delivered words.
        src_q.delete();
        delivered = 0;
        for (int c = 0; c < 60000 && delivered < 10000; c++) begin
            while (src_q.size() < 4) src_q.push_back(8'($urandom));
            run_cycle(1'b0, ($urandom % 4) == 0, ($urandom % 3) != 0);
        end
        chk("stress_words_delivered", delivered >= 10000, 1);
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b1, 1'b1);
        chk("stress_drained", m_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
